// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Assembles a length-prefixed little-endian byte stream into
//               instruction words and writes them to instruction memory.
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader #(
    parameter int MEMORY_DEPTH = 32,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_byte_valid,
    input  logic [7:0]            i_byte,
    output logic                  o_byte_ready,
    output logic                  o_wr_en,
    output logic [DATA_WIDTH-1:0] o_wr_addr,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error
);

    localparam logic [2:0]  c_IDLE  = 3'd0;
    localparam logic [2:0]  c_LEN   = 3'd1;
    localparam logic [2:0]  c_DATA  = 3'd2;
    localparam logic [2:0]  c_DONE  = 3'd3;
    localparam logic [2:0]  c_ERR   = 3'd4;
    localparam logic [16:0] c_DEPTH = 17'(MEMORY_DEPTH);

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [15:0] r_len;
    logic [1:0]  r_byte_cnt;
    logic [15:0] r_word_cnt;
    logic [23:0] r_word_buf;

    logic        w_accept;
    logic        w_idle_like;
    logic [15:0] w_len_full;
    logic        w_word_complete;
    logic        w_last_word;

    assign w_accept        = i_byte_valid && o_byte_ready;
    assign w_idle_like     = (r_state == c_IDLE) || (r_state == c_DONE) || (r_state == c_ERR);
    assign w_len_full      = {i_byte, r_len[7:0]};
    assign w_word_complete = w_accept && (r_state == c_DATA) && (r_byte_cnt == 2'd3);
    assign w_last_word     = (r_word_cnt == (r_len - 16'd1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE, c_DONE, c_ERR: begin
                if (i_start) begin
                    w_next_state = c_LEN;
                end
            end
            c_LEN: begin
                if (w_accept && r_byte_cnt[0]) begin
                    if (w_len_full == 16'd0) begin
                        w_next_state = c_DONE;
                    end else if ({1'b0, w_len_full} > c_DEPTH) begin
                        w_next_state = c_ERR;
                    end else begin
                        w_next_state = c_DATA;
                    end
                end
            end
            c_DATA: begin
                if (w_word_complete && w_last_word) begin
                    w_next_state = c_DONE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        o_byte_ready = 1'b0;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        o_error      = 1'b0;
        case (r_state)
            c_LEN, c_DATA: begin
                o_byte_ready = 1'b1;
                o_busy       = 1'b1;
            end
            c_DONE:  o_done  = 1'b1;
            c_ERR:   o_error = 1'b1;
            default: ;
        endcase
    end

    // Datapath: length capture, byte assembly and the registered write port.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_len      <= '0;
            r_byte_cnt <= '0;
            r_word_cnt <= '0;
            r_word_buf <= '0;
            o_wr_en    <= 1'b0;
            o_wr_addr  <= '0;
            o_wr_data  <= '0;
        end else begin
            o_wr_en <= 1'b0;
            if (w_idle_like && i_start) begin
                r_byte_cnt <= '0;
                r_word_cnt <= '0;
            end else if (w_accept && (r_state == c_LEN)) begin
                if (!r_byte_cnt[0]) begin
                    r_len[7:0] <= i_byte;
                    r_byte_cnt <= 2'd1;
                end else begin
                    r_len[15:8] <= i_byte;
                    r_byte_cnt  <= 2'd0;
                end
            end else if (w_accept && (r_state == c_DATA)) begin
                case (r_byte_cnt)
                    2'd0:    r_word_buf[7:0]   <= i_byte;
                    2'd1:    r_word_buf[15:8]  <= i_byte;
                    2'd2:    r_word_buf[23:16] <= i_byte;
                    default: ;
                endcase
                r_byte_cnt <= r_byte_cnt + 2'd1;
                if (w_word_complete) begin
                    o_wr_en   <= 1'b1;
                    o_wr_data <= DATA_WIDTH'({i_byte, r_word_buf});
                    o_wr_addr <= DATA_WIDTH'({r_word_cnt, 2'b00});
                    // Counter stops at N-1 so it never wraps inside a session.
                    if (!w_last_word) begin
                        r_word_cnt <= r_word_cnt + 16'd1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter MEMORY_DEPTH, default 32: number of instruction words the target instruction memory holds.
REQ-002 Parameter DATA_WIDTH, default 32: instruction word and address width; the byte-assembly logic is fixed at 4 bytes per word.
REQ-003 The block SHALL have exactly these ports:
- i_clk  in  1  sole clock; all state changes on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  begins a new load session.
- i_byte_valid  in  1  the byte on i_byte is valid.
- i_byte  in  8  serial program byte.
- o_byte_ready  out  1  the loader accepts a byte this cycle.
- o_wr_en  out  1  one-cycle write strobe to the instruction memory.
- o_wr_addr  out  DATA_WIDTH  byte address of the write, word-aligned (4*index).
- o_wr_data  out  DATA_WIDTH  assembled instruction word.
- o_busy  out  1  a session is in progress.
- o_done  out  1  the session completed successfully.
- o_error  out  1  the session was aborted because of a length error.

Function
REQ-004 The loader SHALL be an initiator-side writer that fills the instruction memory (read with address bits [DATA_WIDTH-1:2] as the word index) from a byte stream.
REQ-005 The state machine SHALL have the states IDLE, LEN, DATA, DONE and ERR.
REQ-006 A byte SHALL be accepted only on a rising edge where i_byte_valid && o_byte_ready.
REQ-007 o_byte_ready SHALL be 1 in LEN and DATA and 0 in every other state.
REQ-008 In IDLE, DONE or ERR, i_start=1 SHALL move the loader to LEN at the next edge, clear the byte and word counters, and clear o_done and o_error.
REQ-009 i_start SHALL be ignored in LEN and DATA.
REQ-010 In LEN, two accepted bytes SHALL form the 16-bit word count N, little-endian (first byte = N[7:0]).
REQ-011 On the edge that accepts the second length byte, the loader SHALL take exactly one of these transitions:
- N=0: go to DONE.
- N>MEMORY_DEPTH: go to ERR.
- otherwise: go to DATA.
REQ-012 In DATA, every four accepted bytes SHALL form one word, little-endian (first byte = bits [7:0], fourth byte = bits [31:24]).
REQ-013 On the edge that accepts the fourth byte of word k (k = 0..N-1), the loader SHALL register o_wr_data = the assembled word, o_wr_addr = 4*k and o_wr_en = 1.
REQ-014 o_wr_en SHALL be high for exactly one cycle per word; latency is one cycle from the accepting edge.
REQ-015 o_wr_addr and o_wr_data SHALL hold their last values while o_wr_en=0.
REQ-016 On the edge that accepts the fourth byte of word N-1, the state SHALL become DONE, so the final o_wr_en pulse coincides with the first cycle of o_done=1.
REQ-017 o_busy SHALL be 1 exactly in LEN and DATA.
REQ-018 o_done SHALL be 1 exactly in DONE.
REQ-019 o_error SHALL be 1 exactly in ERR.
REQ-020 DONE and ERR SHALL hold until i_start or reset.
REQ-021 Gaps in i_byte_valid, including multi-cycle gaps mid-word, SHALL stall assembly without losing or duplicating bytes.
REQ-022 The word counter SHALL never exceed N-1 and SHALL never wrap within a session.
REQ-023 No write SHALL be issued outside DATA.

Reset
REQ-024 While i_rst_n=0, regardless of clock, the block SHALL drive: state IDLE, o_byte_ready=0, o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_busy=0, o_done=0, o_error=0, and all counters 0.
REQ-025 Reset asserted mid-session SHALL abort immediately with no further write, and any partially assembled word SHALL be discarded.
REQ-026 After reset release, the loader SHALL remain in IDLE until i_start=1.

Verification
REQ-027 Start, then bytes 02 00, 78 56 34 12, EF BE AD DE, with valid held high -> two write pulses, (addr 0x0, data 0x12345678) then (addr 0x4, data 0xDEADBEEF); o_done=1 in the cycle of the second pulse.
REQ-028 Start, length 00 00 -> DONE after the second byte, zero write pulses, o_busy low from that cycle.
REQ-029 Start, length 21 00 (33 > 32) -> ERR, o_error=1, no writes, o_byte_ready=0; a new i_start clears o_error and enters LEN.
REQ-030 Same stream as REQ-027 with random 0-5 cycle valid gaps, including mid-word -> identical write sequence and data.
REQ-031 Reset pulsed after 2 bytes of word 1 -> all outputs at reset values, no second write; a fresh session after reset loads correctly from address 0.
REQ-032 i_start pulsed during DATA, and bytes presented in IDLE -> both ignored; session result unchanged.
